// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-side BTB + PHT predictor.
package branch_predictor_pkg;

  localparam int PhtStateWidth = 2;
  localparam int PhtWbusWidth  = 13;
  localparam int BtbWbusWidth  = 63;
  localparam int BtbTagWidth   = 22;
  localparam int BtbAddrWidth  = 7;
  localparam int PhtAddrWidth  = 10;
  localparam int BtbEntries    = 128;
  localparam int PhtEntries    = 1024;

  // 2-bit saturating counter encoding.
  typedef enum logic [PhtStateWidth-1:0] {
    STRONG_NOT_TAKEN = 2'b00,
    WEAK_NOT_TAKEN   = 2'b01,
    WEAK_TAKEN       = 2'b10,
    STRONG_TAKEN     = 2'b11
  } pht_state_e;

  localparam logic [PhtStateWidth-1:0] PHT_RESET_STATE = WEAK_NOT_TAKEN;

  // Field layout of the PHT update bus, MSB first: {we, idx, next_state}.
  typedef struct packed {
    logic                     we;
    logic [PhtAddrWidth-1:0]  idx;
    logic [PhtStateWidth-1:0] next_state;
  } pht_wbus_t;

  // Field layout of the BTB update bus, MSB first: {we, wvalid, waddr, wtag, wtarget}.
  typedef struct packed {
    logic                    we;
    logic                    wvalid;
    logic [BtbAddrWidth-1:0] waddr;
    logic [BtbTagWidth-1:0]  wtag;
    logic [31:0]             wtarget;
  } btb_wbus_t;

  // One BTB row as stored in the table.
  typedef struct packed {
    logic                   valid;
    logic [BtbTagWidth-1:0] tag;
    logic [31:0]            target;
  } btb_entry_t;

  localparam int BtbEntryWidth = $bits(btb_entry_t);

  // Tag compared against a BTB entry: the PC bits above the index.
  function automatic logic [BtbTagWidth-1:0] btb_tag(input logic [31:0] pc);
    return pc[28:7];
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/EX-facing bundle of the branch predictor.
//
// Handshake: req_valid_i is a one-shot lookup request, accepted at a clock
// edge when stall_i=0 and flush_i=0. The matching response is presented one
// cycle later with predict_valid_o=1 and is held unchanged while stall_i=1;
// flush_i kills it. There is no ready back-pressure: the predictor always
// accepts an unstalled, unflushed request.
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  logic                    req_valid_i;
  logic [31:0]             req_pc_i;
  logic                    stall_i;
  logic                    flush_i;
  logic [PhtWbusWidth-1:0] pht_wbus_i;
  logic [BtbWbusWidth-1:0] btb_wbus_i;

  logic                     predict_valid_o;
  logic [31:0]              predict_pc_o;
  logic                     btb_hit_o;
  logic                     predict_taken_o;
  logic [31:0]              predict_target_o;
  logic [PhtStateWidth-1:0] pht_state_o;

  modport master (
    output req_valid_i, req_pc_i, stall_i, flush_i, pht_wbus_i, btb_wbus_i,
    input  predict_valid_o, predict_pc_o, btb_hit_o, predict_taken_o,
           predict_target_o, pht_state_o
  );

  modport slave (
    input  req_valid_i, req_pc_i, stall_i, flush_i, pht_wbus_i, btb_wbus_i,
    output predict_valid_o, predict_pc_o, btb_hit_o, predict_taken_o,
           predict_target_o, pht_state_o
  );

endinterface

// File: rtl/branch_predictor_bp_table.sv
// Generic direct-mapped table: one read port with write-first bypass, one
// write port applied at the clock edge, optional reset of every row.
module bp_table #(
  parameter int                   Depth     = 128,
  parameter int                   AddrWidth = 7,
  parameter int                   DataWidth = 55,
  parameter bit                   ResetEn   = 1'b1,
  parameter logic [DataWidth-1:0] ResetVal  = '0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i
);

  logic [DataWidth-1:0] mem_q [Depth];

  // Read the addressed row; a same-edge write to that row wins.
  always_comb begin
    rdata_o = mem_q[raddr_i];
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_o = wdata_i;
    end
  end

  if (ResetEn) begin : g_rst
    // Row storage, cleared to ResetVal while resetn is low.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int i = 0; i < Depth; i++) begin
          mem_q[i] <= ResetVal;
        end
      end else if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
    end
  end else begin : g_nrst
    // Row storage without reset.
    always_ff @(posedge clk) begin
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: 128-entry BTB + 1024-entry PHT, one-cycle
// lookup latency, updates from the EX-stage resolution unit.
module branch_predictor
  import branch_predictor_pkg::*;
(
  input logic              clk,
  input logic              resetn,
  branch_predictor_if.slave bus
);

  pht_wbus_t  pht_wbus;
  btb_wbus_t  btb_wbus;
  btb_entry_t btb_wr;
  btb_entry_t btb_rd;
  logic [PhtStateWidth-1:0] pht_rd;

  assign pht_wbus = bus.pht_wbus_i;
  assign btb_wbus = bus.btb_wbus_i;
  assign btb_wr   = '{valid: btb_wbus.wvalid, tag: btb_wbus.wtag, target: btb_wbus.wtarget};

  bp_table #(
    .Depth    (BtbEntries),
    .AddrWidth(BtbAddrWidth),
    .DataWidth(BtbEntryWidth),
    .ResetEn  (1'b1),
    .ResetVal ('0)
  ) u_btb (
    .clk    (clk),
    .resetn (resetn),
    .raddr_i(bus.req_pc_i[6:0]),
    .rdata_o(btb_rd),
    .we_i   (btb_wbus.we),
    .waddr_i(btb_wbus.waddr),
    .wdata_i(btb_wr)
  );

  bp_table #(
    .Depth    (PhtEntries),
    .AddrWidth(PhtAddrWidth),
    .DataWidth(PhtStateWidth),
    .ResetEn  (1'b1),
    .ResetVal (PHT_RESET_STATE)
  ) u_pht (
    .clk    (clk),
    .resetn (resetn),
    .raddr_i(bus.req_pc_i[12:3]),
    .rdata_o(pht_rd),
    .we_i   (pht_wbus.we),
    .waddr_i(pht_wbus.idx),
    .wdata_i(pht_wbus.next_state)
  );

  logic                     valid_q,  valid_d;
  logic [31:0]              pc_q,     pc_d;
  logic                     hit_q,    hit_d;
  logic                     taken_q,  taken_d;
  logic [31:0]              target_q, target_d;
  logic [PhtStateWidth-1:0] state_q,  state_d;

  logic        lookup_hit;
  logic [31:0] fall_through;

  assign lookup_hit   = btb_rd.valid && (btb_rd.tag == btb_tag(bus.req_pc_i));
  assign fall_through = bus.req_pc_i + 32'd4;

  // Next response: flush kills it, stall freezes it, otherwise capture a new lookup.
  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    hit_d    = hit_q;
    taken_d  = taken_q;
    target_d = target_q;
    state_d  = state_q;
    if (bus.flush_i) begin
      valid_d = 1'b0;
    end else if (!bus.stall_i) begin
      if (bus.req_valid_i) begin
        valid_d  = 1'b1;
        pc_d     = bus.req_pc_i;
        hit_d    = lookup_hit;
        taken_d  = lookup_hit & pht_rd[1];
        target_d = lookup_hit ? btb_rd.target : fall_through;
        state_d  = pht_rd;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Response registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      hit_q    <= 1'b0;
      taken_q  <= 1'b0;
      target_q <= '0;
      state_q  <= PHT_RESET_STATE;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      hit_q    <= hit_d;
      taken_q  <= taken_d;
      target_q <= target_d;
      state_q  <= state_d;
    end
  end

  assign bus.predict_valid_o  = valid_q;
  assign bus.predict_pc_o     = pc_q;
  assign bus.btb_hit_o        = hit_q;
  assign bus.predict_taken_o  = taken_q;
  assign bus.predict_target_o = target_q;
  assign bus.pht_state_o      = state_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a queue-based response scoreboard.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  localparam int W = 68;  // {pc[31:0], hit, taken, target[31:0], state[1:0]}

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if bp_if_i ();

  branch_predictor dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bp_if_i)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           tests_run    = 0;
  int           tests_failed = 0;
  logic [W-1:0] snap;

  function automatic logic [W-1:0] mk(input logic [31:0] pc, input logic hit,
                                      input logic taken, input logic [31:0] tgt,
                                      input logic [1:0] st);
    return {pc, hit, taken, tgt, st};
  endfunction

  function automatic logic [W-1:0] dut_rsp();
    return {bp_if_i.predict_pc_o, bp_if_i.btb_hit_o, bp_if_i.predict_taken_o,
            bp_if_i.predict_target_o, bp_if_i.pht_state_o};
  endfunction

  function automatic logic [21:0] tag_of(input logic [31:0] pc);
    return pc[28:7];
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Monitor: a response is consumed when valid and neither stalled nor flushed.
  always @(negedge clk) begin
    if (resetn && bp_if_i.predict_valid_o && !bp_if_i.stall_i && !bp_if_i.flush_i) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_rsp: got %h required no response", dut_rsp());
      end else begin
        check(name_q.pop_front(), dut_rsp(), exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bp_if_i.req_valid_i = 1'b0;
    bp_if_i.req_pc_i    = '0;
    bp_if_i.stall_i     = 1'b0;
    bp_if_i.flush_i     = 1'b0;
    bp_if_i.pht_wbus_i  = '0;
    bp_if_i.btb_wbus_i  = '0;
  endtask

  task automatic expect_rsp(input string name, input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic do_req(input string name, input logic [31:0] pc, input logic [W-1:0] e);
    bp_if_i.req_valid_i = 1'b1;
    bp_if_i.req_pc_i    = pc;
    expect_rsp(name, e);
    tick();
    bp_if_i.req_valid_i = 1'b0;
    tick();
  endtask

  task automatic set_pht(input logic [9:0] idx, input logic [1:0] st);
    bp_if_i.pht_wbus_i = {1'b1, idx, st};
  endtask

  task automatic set_btb(input logic [6:0] addr, input logic v, input logic [21:0] tag,
                         input logic [31:0] tgt);
    bp_if_i.btb_wbus_i = {1'b1, v, addr, tag, tgt};
  endtask

  task automatic check_valid(input string name, input logic exp);
    check(name, {{(W-1){1'b0}}, bp_if_i.predict_valid_o}, {{(W-1){1'b0}}, exp});
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no end of test required end before 200000");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    clear_in();
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    tick();

    // Reset state.
    check_valid("reset_valid", 1'b0);
    check("reset_outputs", dut_rsp(), mk(32'h0, 1'b0, 1'b0, 32'h0, 2'b01));

    // Cold lookup: miss, fall-through target, reset counter.
    do_req("cold_miss", 32'h1C00_0000, mk(32'h1C00_0000, 0, 0, 32'h1C00_0004, 2'b01));

    // Train BTB row 0x10 and PHT idx 2 on the same edge.
    set_btb(7'h10, 1'b1, tag_of(32'h1C00_0010), 32'h1C00_0100);
    set_pht(10'd2, 2'b11);
    tick();
    clear_in();
    do_req("trained_hit", 32'h1C00_0010, mk(32'h1C00_0010, 1, 1, 32'h1C00_0100, 2'b11));

    // Alias: same BTB row, different tag.
    do_req("alias_miss", 32'h1C00_0090, mk(32'h1C00_0090, 0, 0, 32'h1C00_0094, 2'b01));

    // Strongly-taken counter on a BTB miss must not predict taken.
    set_pht(10'h12, 2'b11);
    tick();
    clear_in();
    do_req("miss_strong", 32'h1C00_0090, mk(32'h1C00_0090, 0, 0, 32'h1C00_0094, 2'b11));

    // Weakly-taken counter on a hit predicts taken.
    set_pht(10'd2, 2'b10);
    tick();
    clear_in();
    do_req("hit_weak_taken", 32'h1C00_0010, mk(32'h1C00_0010, 1, 1, 32'h1C00_0100, 2'b10));

    // PHT write-first bypass.
    bp_if_i.req_valid_i = 1'b1;
    bp_if_i.req_pc_i    = 32'h1C00_0010;
    set_pht(10'd2, 2'b00);
    expect_rsp("pht_bypass", mk(32'h1C00_0010, 1, 0, 32'h1C00_0100, 2'b00));
    tick();
    clear_in();
    tick();

    // BTB write-first bypass: row 0x10 retagged to the alias PC on the read edge.
    bp_if_i.req_valid_i = 1'b1;
    bp_if_i.req_pc_i    = 32'h1C00_0090;
    set_btb(7'h10, 1'b1, tag_of(32'h1C00_0090), 32'h2000_0000);
    expect_rsp("btb_bypass", mk(32'h1C00_0090, 1, 1, 32'h2000_0000, 2'b11));
    tick();
    clear_in();
    tick();

    // Stall: response held, a new request during stall ignored.
    bp_if_i.req_valid_i = 1'b1;
    bp_if_i.req_pc_i    = 32'h1C00_0090;
    expect_rsp("stall_release", mk(32'h1C00_0090, 1, 1, 32'h2000_0000, 2'b11));
    tick();
    bp_if_i.stall_i  = 1'b1;
    bp_if_i.req_pc_i = 32'h1C00_0000;
    @(negedge clk);
    snap = dut_rsp();
    check_valid("stall_valid0", 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold", dut_rsp(), snap);
      check_valid("stall_valid", 1'b1);
    end
    @(posedge clk);
    #1;
    clear_in();
    tick();

    // Flush together with a request: nothing is accepted.
    bp_if_i.req_valid_i = 1'b1;
    bp_if_i.flush_i     = 1'b1;
    bp_if_i.req_pc_i    = 32'h1C00_0000;
    tick();
    check_valid("flush_with_req", 1'b0);
    clear_in();
    tick();

    // Flush beats stall and request, killing a pending response.
    bp_if_i.req_valid_i = 1'b1;
    bp_if_i.req_pc_i    = 32'h1C00_0000;
    tick();
    check_valid("flush_pre_valid", 1'b1);
    bp_if_i.flush_i  = 1'b1;
    bp_if_i.stall_i  = 1'b1;
    bp_if_i.req_pc_i = 32'h1C00_0010;
    tick();
    check_valid("flush_over_stall", 1'b0);
    clear_in();
    tick();

    // Invalidate row 0x10.
    set_btb(7'h10, 1'b0, tag_of(32'h1C00_0090), 32'h2000_0000);
    tick();
    clear_in();
    do_req("inval_alias", 32'h1C00_0090, mk(32'h1C00_0090, 0, 0, 32'h1C00_0094, 2'b11));
    do_req("inval_orig",  32'h1C00_0010, mk(32'h1C00_0010, 0, 0, 32'h1C00_0014, 2'b00));

    // Fall-through wraps modulo 2^32.
    do_req("wrap", 32'hFFFF_FFFC, mk(32'hFFFF_FFFC, 0, 0, 32'h0000_0000, 2'b01));

    // Retrain, then reset mid-stream.
    set_btb(7'h10, 1'b1, tag_of(32'h1C00_0010), 32'h1C00_0100);
    set_pht(10'd2, 2'b11);
    tick();
    clear_in();
    do_req("retrained_hit", 32'h1C00_0010, mk(32'h1C00_0010, 1, 1, 32'h1C00_0100, 2'b11));

    bp_if_i.req_valid_i = 1'b1;
    bp_if_i.req_pc_i    = 32'h1C00_0010;
    tick();
    check_valid("pre_reset_valid", 1'b1);
    bp_if_i.req_valid_i = 1'b0;
    #1;
    resetn = 1'b0;
    #1;
    check_valid("async_reset_valid", 1'b0);
    check("async_reset_outputs", dut_rsp(), mk(32'h0, 0, 0, 32'h0, 2'b01));
    // Update seen while in reset must be ignored.
    set_pht(10'd2, 2'b11);
    tick();
    clear_in();
    resetn = 1'b1;
    tick();
    do_req("post_reset_miss", 32'h1C00_0010, mk(32'h1C00_0010, 0, 0, 32'h1C00_0014, 2'b01));

    // Every expected response must have been seen.
    tick();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d responses outstanding required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
